// File: rtl/fp_const_pkg.sv
// Shared single-precision constants, coefficient ROM, error codes and the ln FSM states.
package fp_const_pkg;

  localparam logic [31:0] LN2        = 32'h3F317218;
  localparam logic [31:0] ONE        = 32'h3F800000;
  localparam logic [31:0] TWO        = 32'h40000000;
  localparam logic [22:0] SQRT2_MANT = 23'h3504F3;
  localparam logic [31:0] QNAN       = 32'h7FC00000;
  localparam logic [31:0] NEG_INF    = 32'hFF800000;
  localparam logic [31:0] POS_INF    = 32'h7F800000;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_DOMAIN = 2'b01;
  localparam logic [1:0] ERR_POLE   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_NUM, S_DEN, S_DIV, S_SQ, S_POW, S_SCALE, S_ACC, S_DBL, S_EK, S_SUM, S_DONE
  } ln_state_e;

  // C[k] = 1/(2k+1) for the odd atanh series terms
  function automatic logic [31:0] coef(input logic [2:0] k);
    case (k)
      3'd1:    coef = 32'h3EAAAAAB;
      3'd2:    coef = 32'h3E4CCCCD;
      3'd3:    coef = 32'h3E124925;
      3'd4:    coef = 32'h3DE38E39;
      3'd5:    coef = 32'h3DBA2E8C;
      3'd6:    coef = 32'h3D9D89D9;
      3'd7:    coef = 32'h3D888889;
      default: coef = ONE;
    endcase
  endfunction

endpackage

// File: rtl/fp_add.sv
// Library float adder/subtractor: three guard bits during alignment, truncated result.
module fp_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] y
);

  logic [31:0] bb_s, big_s, small_s;
  logic [26:0] big_m_s, small_m_s, shifted_s;
  logic [7:0]  diff_s;
  logic [27:0] sum_s, norm_s;
  logic [4:0]  pos_s;
  logic [9:0]  exp_s;

  assign bb_s = {b[31] ^ sub, b[30:0]};

  // order by magnitude, align, add or subtract, renormalise
  always_comb begin
    if (a[30:0] >= bb_s[30:0]) begin
      big_s   = a;
      small_s = bb_s;
    end else begin
      big_s   = bb_s;
      small_s = a;
    end
    big_m_s   = (big_s[30:23] != 8'h00) ? {1'b1, big_s[22:0], 3'b000} : 27'h0;
    small_m_s = (small_s[30:23] != 8'h00) ? {1'b1, small_s[22:0], 3'b000} : 27'h0;
    diff_s    = big_s[30:23] - small_s[30:23];
    shifted_s = (diff_s > 8'd26) ? 27'h0 : (small_m_s >> diff_s);
    if (big_s[31] == small_s[31]) begin
      sum_s = {1'b0, big_m_s} + {1'b0, shifted_s};
    end else begin
      sum_s = {1'b0, big_m_s} - {1'b0, shifted_s};
    end
    pos_s = 5'd0;
    for (int i = 0; i < 28; i++) begin
      if (sum_s[i]) pos_s = 5'(i);
      else          pos_s = pos_s;
    end
    norm_s = sum_s << (5'd27 - pos_s);
    exp_s  = {2'b00, big_s[30:23]} + {5'b00000, pos_s} - 10'd26;
    if (sum_s == 28'h0) begin
      y = 32'h0;
    end else if (exp_s[9] || exp_s == 10'd0) begin
      y = {big_s[31], 31'h0};
    end else if (exp_s >= 10'd255) begin
      y = {big_s[31], 8'hFF, 23'h0};
    end else begin
      y = {big_s[31], exp_s[7:0], 23'(norm_s >> 4)};
    end
  end

endmodule

// File: rtl/fp_div.sv
// Library float divider: single-pass integer mantissa quotient, truncated.
module fp_div (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [24:0] quo_s;
  logic [9:0]  exp_s;
  logic [22:0] mant_s;
  logic        sign_s;

  assign sign_s = a[31] ^ b[31];
  assign quo_s  = 25'({1'b1, a[22:0], 24'h0} / {24'h0, 1'b1, b[22:0]});

  // normalise the quotient and pack the result
  always_comb begin
    if (quo_s[24]) begin
      mant_s = quo_s[23:1];
      exp_s  = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127;
    end else begin
      mant_s = quo_s[22:0];
      exp_s  = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd126;
    end
    if (a[30:23] == 8'h00) begin
      y = 32'h0;
    end else if (b[30:23] == 8'h00) begin
      y = {sign_s, 8'hFF, 23'h0};
    end else if (exp_s[9] || exp_s == 10'd0) begin
      y = {sign_s, 31'h0};
    end else if (exp_s >= 10'd255) begin
      y = {sign_s, 8'hFF, 23'h0};
    end else begin
      y = {sign_s, exp_s[7:0], mant_s};
    end
  end

endmodule

// File: rtl/fp_ln_unpack.sv
// Classifies the ln operand and range-reduces it to m in [0.707, 1.414] with x = m * 2^e.
module fp_ln_unpack
  import fp_const_pkg::*;
(
  input  logic [31:0] x,
  output logic        special,
  output logic [31:0] special_out,
  output logic [1:0]  special_err,
  output logic [8:0]  e,
  output logic [31:0] m
);

  logic [7:0]  exp_s;
  logic [22:0] mant_s;

  assign exp_s  = x[30:23];
  assign mant_s = x[22:0];

  // special cases; denormals count as zero and therefore as the pole
  always_comb begin
    special     = 1'b1;
    special_out = 32'h0;
    special_err = ERR_OK;
    if (exp_s == 8'h00) begin
      special_out = NEG_INF;
      special_err = ERR_POLE;
    end else if (exp_s == 8'hFF && mant_s != 23'h0) begin
      special_out = QNAN;
      special_err = ERR_DOMAIN;
    end else if (x[31]) begin
      special_out = QNAN;
      special_err = ERR_DOMAIN;
    end else if (exp_s == 8'hFF) begin
      special_out = POS_INF;
    end else if (x == ONE) begin
      special_out = 32'h0;
    end else begin
      special = 1'b0;
    end
  end

  // fold mantissas above sqrt2 into the lower octave and bump the exponent
  always_comb begin
    if (mant_s > SQRT2_MANT) begin
      m = {1'b0, 8'h7E, mant_s};
      e = {1'b0, exp_s} - 9'd126;
    end else begin
      m = {1'b0, 8'h7F, mant_s};
      e = {1'b0, exp_s} - 9'd127;
    end
  end

endmodule

// File: rtl/fp_mul.sv
// Library float multiplier: truncating, denormals flushed to zero, saturates to inf.
module fp_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [47:0] prod_s;
  logic [9:0]  exp_s;
  logic [22:0] mant_s;
  logic        sign_s;

  assign sign_s = a[31] ^ b[31];
  assign prod_s = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};

  // normalise the 48-bit product and pack the result
  always_comb begin
    if (prod_s[47]) begin
      mant_s = 23'(prod_s >> 24);
      exp_s  = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd126;
    end else begin
      mant_s = 23'(prod_s >> 23);
      exp_s  = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    end
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
      y = 32'h0;
    end else if (exp_s[9] || exp_s == 10'd0) begin
      y = {sign_s, 31'h0};
    end else if (exp_s >= 10'd255) begin
      y = {sign_s, 8'hFF, 23'h0};
    end else begin
      y = {sign_s, exp_s[7:0], mant_s};
    end
  end

endmodule

// File: rtl/int_to_float.sv
// Unsigned integer to single precision; exact for values below 2^24.
module int_to_float #(
  parameter int W = 16
) (
  input  logic [W-1:0] val,
  output logic [31:0]  y
);

  logic [4:0] pos_s;

  // locate the leading one and left-justify the mantissa under it
  always_comb begin
    pos_s = 5'd0;
    for (int i = 0; i < W; i++) begin
      if (val[i]) pos_s = 5'(i);
      else        pos_s = pos_s;
    end
    if (val == '0) begin
      y = 32'h0;
    end else begin
      y = {1'b0, 8'd127 + {3'b000, pos_s}, 23'((64'(val) << 23) >> pos_s)};
    end
  end

endmodule

// File: rtl/fp_ln.sv
// Multi-cycle single-precision ln(x) = 2*atanh((m-1)/(m+1)) + e*ln2 on one shared mul/add/div.
module fp_ln
  import fp_const_pkg::*;
#(
  parameter int N_TERMS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic [1:0]  error
);

  ln_state_e   state_r;
  logic [31:0] m_r, num_r, den_r, z_r, z2_r, p_r, t_r, acc_r, ek_r, out_r, spec_out_r;
  logic [8:0]  e_r;
  logic [2:0]  k_r;
  logic        spec_r, out_valid_r;
  logic [1:0]  spec_err_r, error_r;

  logic        spec_s;
  logic [31:0] spec_out_s, m_s;
  logic [1:0]  spec_err_s;
  logic [8:0]  e_s, e_abs_s;
  logic [31:0] i2f_y_s, mul_a_s, mul_b_s, mul_y_s, add_a_s, add_b_s, add_y_s, div_y_s;
  logic        add_sub_s;

  fp_ln_unpack u_unpack (
    .x(x), .special(spec_s), .special_out(spec_out_s), .special_err(spec_err_s),
    .e(e_s), .m(m_s)
  );

  assign e_abs_s = e_r[8] ? (9'd0 - e_r) : e_r;

  int_to_float #(.W(9)) u_i2f (.val(e_abs_s), .y(i2f_y_s));
  fp_mul u_mul (.a(mul_a_s), .b(mul_b_s), .y(mul_y_s));
  fp_add u_add (.a(add_a_s), .b(add_b_s), .sub(add_sub_s), .y(add_y_s));
  fp_div u_div (.a(num_r), .b(den_r), .y(div_y_s));

  // shared-unit operand selection by state
  always_comb begin
    mul_a_s   = p_r;
    mul_b_s   = z2_r;
    add_a_s   = acc_r;
    add_b_s   = t_r;
    add_sub_s = 1'b0;
    case (state_r)
      S_NUM: begin
        add_a_s   = m_r;
        add_b_s   = ONE;
        add_sub_s = 1'b1;
      end
      S_DEN: begin
        add_a_s = m_r;
        add_b_s = ONE;
      end
      S_SQ: begin
        mul_a_s = z_r;
        mul_b_s = z_r;
      end
      S_SCALE: mul_b_s = coef(k_r);
      S_DBL: begin
        mul_a_s = acc_r;
        mul_b_s = TWO;
      end
      S_EK: begin
        mul_a_s = i2f_y_s;
        mul_b_s = LN2;
      end
      S_SUM:   add_b_s = ek_r;
      default: add_sub_s = 1'b0;
    endcase
  end

  // sequencer and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      m_r         <= 32'h0;
      e_r         <= 9'd0;
      spec_r      <= 1'b0;
      spec_out_r  <= 32'h0;
      spec_err_r  <= ERR_OK;
      num_r       <= 32'h0;
      den_r       <= 32'h0;
      z_r         <= 32'h0;
      z2_r        <= 32'h0;
      p_r         <= 32'h0;
      t_r         <= 32'h0;
      acc_r       <= 32'h0;
      ek_r        <= 32'h0;
      k_r         <= 3'd0;
      out_r       <= 32'h0;
      error_r     <= ERR_OK;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            m_r        <= m_s;
            e_r        <= e_s;
            spec_r     <= spec_s;
            spec_out_r <= spec_out_s;
            spec_err_r <= spec_err_s;
            state_r    <= S_NUM;
          end
        end
        S_NUM: begin
          if (spec_r) begin
            out_r       <= spec_out_r;
            error_r     <= spec_err_r;
            out_valid_r <= 1'b1;
            state_r     <= S_DONE;
          end else begin
            num_r   <= add_y_s;
            state_r <= S_DEN;
          end
        end
        S_DEN: begin
          den_r   <= add_y_s;
          state_r <= S_DIV;
        end
        S_DIV: begin
          z_r     <= div_y_s;
          acc_r   <= div_y_s;
          p_r     <= div_y_s;
          state_r <= S_SQ;
        end
        S_SQ: begin
          z2_r    <= mul_y_s;
          k_r     <= 3'd1;
          state_r <= S_POW;
        end
        S_POW: begin
          p_r     <= mul_y_s;
          state_r <= S_SCALE;
        end
        S_SCALE: begin
          t_r     <= mul_y_s;
          state_r <= S_ACC;
        end
        S_ACC: begin
          acc_r   <= add_y_s;
          k_r     <= k_r + 3'd1;
          state_r <= (k_r == 3'(N_TERMS - 1)) ? S_DBL : S_POW;
        end
        S_DBL: begin
          acc_r   <= mul_y_s;
          state_r <= S_EK;
        end
        S_EK: begin
          ek_r    <= {e_r[8], mul_y_s[30:0]};
          state_r <= S_SUM;
        end
        S_SUM: begin
          out_r       <= add_y_s;
          error_r     <= ERR_OK;
          out_valid_r <= 1'b1;
          state_r     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_r == S_IDLE) && !reset;
  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign error     = error_r;

endmodule

// File: tb/tb_fp_ln.sv
// Bench for fp_ln: directed corner cases plus random operands against a real-number ln model.
module tb_fp_ln;

  localparam int N_TERMS = 5;
  localparam int LAT     = 7 + 3 * (N_TERMS - 1);

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] x, out;
  logic [1:0]  error;
  int          total = 0;
  int          bad   = 0;

  fp_ln #(.N_TERMS(N_TERMS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input real got, input real want, input real tol);
    total++;
    if ((got > want + tol) || (got < want - tol)) begin
      bad++;
      $display("FAIL %s: got %0.8f want %0.8f (tol %g)", tag, got, want, tol);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    real v;
    int  ex;
    ex = int'(f[30:23]);
    if (ex == 0) return 0.0;
    v = (1.0 + real'(f[22:0]) / 8388608.0) * $pow(2.0, real'(ex - 127));
    return f[31] ? -v : v;
  endfunction

  // Reference: IEEE special-value rules, otherwise the real-valued logarithm.
  task automatic model(input logic [31:0] xv, output bit spec, output logic [31:0] so,
                       output logic [1:0] se, output real lnv);
    spec = 1'b1; so = 32'h0; se = 2'b00; lnv = 0.0;
    if (xv[30:23] == 8'h00) begin
      so = 32'hFF800000; se = 2'b10;
    end else if (xv[30:23] == 8'hFF && xv[22:0] != 23'h0) begin
      so = 32'h7FC00000; se = 2'b01;
    end else if (xv[31]) begin
      so = 32'h7FC00000; se = 2'b01;
    end else if (xv[30:23] == 8'hFF) begin
      so = 32'h7F800000;
    end else if (xv == 32'h3F800000) begin
      so = 32'h0;
    end else begin
      spec = 1'b0;
      lnv  = $ln(f2r(xv));
    end
  endtask

  function automatic real ln_tol(input real lnv);
    real a;
    a = (lnv < 0.0) ? -lnv : lnv;
    return (a < 0.1) ? 2.0e-5 : 1.0e-4 * a;
  endfunction

  task automatic run_op(input logic [31:0] xv, input string tag);
    bit          spec;
    logic [31:0] so;
    logic [1:0]  se;
    real         lnv;
    int          n, lat;
    model(xv, spec, so, se, lnv);
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready"}, real'(in_ready), 1.0, 0.0);
    x = xv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_lat"}, real'(lat), spec ? 1.0 : real'(LAT), 0.0);
    check({tag, "_err"}, real'(error), real'(se), 0.0);
    if (spec) check({tag, "_out"}, real'(out), real'(so), 0.0);
    else      check({tag, "_ln"}, f2r(out), lnv, ln_tol(lnv));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, real'(out_valid), 0.0, 0.0);
    check({tag, "_rdy_back"}, real'(in_ready), 1.0, 0.0);
  endtask

  initial begin
    logic [31:0] r, xv;
    int          n, seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", real'(out_valid), 0.0, 0.0);
    check("rst_out", real'(out), 0.0, 0.0);
    check("rst_err", real'(error), 0.0, 0.0);
    check("rst_rdy", real'(in_ready), 0.0, 0.0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rdy_after_rst", real'(in_ready), 1.0, 0.0);

    run_op(32'h3F800000, "one");
    run_op(32'h402DF854, "e");
    run_op(32'h3F000000, "half");
    run_op(32'h41200000, "ten");
    run_op(32'h00000000, "zero");
    run_op(32'h80000000, "negzero");
    run_op(32'hC0000000, "neg2");
    run_op(32'h7F800000, "inf");
    run_op(32'h7FC00001, "nan");
    run_op(32'hFF800000, "neginf");
    run_op(32'h00000001, "denorm");
    run_op(32'h7F7FFFFF, "maxnorm");
    run_op(32'h00800000, "minnorm");
    run_op(32'h3FB504F3, "sqrt2_lo");
    run_op(32'h3FB504F4, "sqrt2_hi");

    // back-pressure: result must hold while the consumer stalls
    x = 32'h402DF854; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("bp_lat", real'(n), real'(LAT), 0.0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_out", f2r(out), 1.0, 1.0e-4);
      check("bp_err", real'(error), 0.0, 0.0);
      check("bp_vld", real'(out_valid), 1.0, 0.0);
      check("bp_rdy", real'(in_ready), 0.0, 0.0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_vld_drop", real'(out_valid), 0.0, 0.0);
    check("bp_rdy_back", real'(in_ready), 1.0, 0.0);

    // reset in mid-operation aborts without a result
    x = 32'h41200000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_rdy_in_rst", real'(in_ready), 0.0, 0.0);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_vld", real'(seen), 0.0, 0.0);
    check("abort_out", real'(out), 0.0, 0.0);
    check("abort_rdy", real'(in_ready), 1.0, 0.0);
    run_op(32'h40000000, "two_after_rst");

    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0:       xv = r;
        1, 2:    xv = {1'b0, 8'($urandom_range(100, 160)), r[22:0]};
        default: xv = {1'b0, (r[23] ? 8'h7E : 8'h7F), r[22:0]};
      endcase
      run_op(xv, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_ln.md
Name: fp_ln

Overview:
- Multi-cycle IEEE-754 single-precision natural logarithm, ln(x). It is the inverse of the exponential unit in the shared float math library.
- Feeds the neuron/muscle model datapath wherever log-domain quantities are needed.
- One input word is accepted per operation with a valid/ready handshake. The range-reduced series is computed over successive cycles on a single shared multiplier, adder/subtractor and divider.
- The result is presented with valid/ready back-pressure.

Parameters:
- N_TERMS, 5: number of odd series terms z^(2k+1)/(2k+1), k=0..N_TERMS-1. Legal range 2..8.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  x is valid.
- in_ready  out  1  block can accept x; high only in IDLE and while reset is low.
- x  in  32  IEEE-754 single operand.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- out  out  32  ln(x), IEEE-754 single.
- error  out  2  00 ok, 01 domain (x<0 or NaN), 10 pole (x==0).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values:
  - state = IDLE, out_valid = 0, out = 0, error = 00.
  - All datapath registers clear to 0.
  - in_ready = 0 while reset is high.
  - A reset asserted mid-operation aborts the operation. No result is produced.
- Accept: in the cycle in_valid && in_ready, x is captured and the FSM leaves IDLE.
- Special cases: these go to DONE on the next cycle (latency 1). Denormal x is treated as zero.
  - exp==0: out = 0xFF800000, error = 10.
  - sign==1 with nonzero magnitude: out = 0x7FC00000, error = 01.
  - x NaN: out = 0x7FC00000, error = 01.
  - x = +inf: out = 0x7F800000, error = 00.
  - x = 0x3F800000: out = 0x00000000, error = 00.
- Range reduction, done at capture:
  - e = exp - 127 (signed 9-bit).
  - m = {0, 0x7F, mant}.
  - If mant > 0x3504F3 (m > sqrt2): m exponent becomes 0x7E and e = e + 1.
  - Result: m is in [0.707, 1.414].
- Normal path states, one cycle each:
  - NUM: num <= m - 1.
  - DEN: den <= m + 1.
  - DIV: z <= num/den; acc <= z; p <= z.
  - SQ: z2 <= z*z; k <= 1.
  - POW: p <= p*z2.
  - SCALE: t <= p*C[k], where C[k] = 1/(2k+1).
  - ACC: acc <= acc + t; k <= k + 1. If k == N_TERMS-1, go to DBL, else go to POW.
  - DBL: acc <= acc with exponent + 1; stays 0 if acc == 0.
  - EK: ek <= float(|e|) * LN2, sign = sign(e). float(0) = 0.
  - SUM: out <= acc + ek; error <= 00.
  - DONE.
- Latency: out_valid rises 7 + 3*(N_TERMS-1) cycles after the accept edge, i.e. 19 at the default.
- DONE:
  - out_valid = 1.
  - out and error are held stable while out_ready = 0.
  - On out_ready, go to IDLE. out_valid is 0 in the next cycle; in_ready is 1 in the next cycle.
  - There is no overlap of operations. Throughput is one result per latency + 2 cycles.
- Arithmetic:
  - Multiplier, adder and divider behave exactly as the library float units do (truncating multiplier, no rounding).
  - Overflow/underflow flags from the internal units are ignored. Only the 2-bit error defined above is reported.
- Accuracy: relative error ≤ 1e-4, and absolute error ≤ 2e-5 when |ln x| < 0.1.

Decomposition:
- Shared package fp_const_pkg holds:
  - LN2 = 0x3F317218, ONE = 0x3F800000, TWO = 0x40000000.
  - SQRT2_MANT = 0x3504F3.
  - QNAN = 0x7FC00000, NEG_INF = 0xFF800000, POS_INF = 0x7F800000.
  - Coefficient ROM C[1..7] = 1/3, 1/5, 1/7, 1/9, 1/11, 1/13, 1/15 as single-precision words.
  - Error codes and the state enum.
- Sub-module fp_ln_unpack (combinational): special-case classification, e, range-reduced m.
- Top level: FSM plus one instance each of the multiplier, adder/subtractor and divider, with operand muxes selected by state.
- Reuses the existing int_to_float.

Test Plan:
- x = 0x3F800000 -> out = 0x00000000, error = 00, out_valid 1 cycle after accept.
- x = 0x402DF854 (e) -> out within 1e-4 of 0x3F800000, error = 00, out_valid exactly 19 cycles after accept.
- x = 0x3F000000 (0.5) and x = 0x41200000 (10) -> out within 1e-4 relative of -0.693147 (0xBF317218) and 2.302585 (0x40135D8E).
- x = 0x00000000, x = 0x80000000, x = 0xC0000000, x = 0x7F800000 -> respectively:
  - 0xFF800000 / 10
  - 0xFF800000 / 10
  - 0x7FC00000 / 01
  - 0x7F800000 / 00
- Back-pressure: hold out_ready = 0 for 5 cycles in DONE -> out, error and out_valid stable. in_ready stays 0 until the cycle after the handshake.
- Reset asserted 5 cycles after an accept -> out_valid stays 0 and in_ready returns to 1 after reset. A following x = 0x40000000 yields 0.693147 within 1e-4.
